// File: rtl/uart_transmitter.sv
`timescale 1ns/1ps
// 8N1 UART transmitter: valid/ready byte intake, small circular FIFO, and a
// start/data/stop serialiser paced by a clock-cycle baud divider.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       uart_out,
  output logic       tx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] BAUD_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   COUNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_baud;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_uart_out;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_baud_last;

  assign w_full      = (r_count == COUNT_FULL);
  assign w_empty     = (r_count == '0);
  // A full FIFO refuses the push even when the serialiser pops on this edge.
  assign w_push      = tx_valid && !w_full;
  assign w_baud_last = (r_baud == BAUD_LAST);
  assign w_pop       = !w_empty &&
                       ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_last));

  // NOTE: the data array has no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= tx_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, matching the hardware.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_uart_out <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shift    <= r_mem[r_rd_ptr];
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_uart_out <= 1'b0;
            r_state    <= S_START;
          end
        end
        S_START: begin
          if (w_baud_last) begin
            r_baud     <= '0;
            r_uart_out <= r_shift[0];
            r_state    <= S_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (w_baud_last) begin
            r_baud <= '0;
            if (r_bit_idx == 3'd7) begin
              r_uart_out <= 1'b1;
              r_state    <= S_STOP;
            end else begin
              // The line register is loaded with the bit that becomes shift[0].
              r_shift    <= {1'b0, r_shift[7:1]};
              r_uart_out <= r_shift[1];
              r_bit_idx  <= r_bit_idx + 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_STOP: begin
          if (w_baud_last) begin
            r_baud <= '0;
            if (w_pop) begin
              r_shift    <= r_mem[r_rd_ptr];
              r_bit_idx  <= '0;
              r_uart_out <= 1'b0;
              r_state    <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_ready = !w_full;
  assign uart_out = r_uart_out;
  assign tx_busy  = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_uart_transmitter.sv
`timescale 1ns/1ps
// Directed bench for uart_transmitter: a fast instance (4 clocks/bit) for
// framing, FIFO and reset behaviour, and a default instance for bit timing.
module tb_uart_transmitter;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, uart_out, tx_busy;
  logic [7:0] tx_data_d = 8'h00;
  logic       tx_valid_d = 1'b0;
  logic       tx_ready_d, uart_out_d, tx_busy_d;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int cyc = 0;

  logic       dec_en = 1'b0;
  logic [7:0] dec_q[$];
  int         start_q[$];
  int         stop_bad = 0;
  logic [7:0] dec_byte;
  int         dec_start;

  uart_transmitter #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .uart_out(uart_out), .tx_busy(tx_busy)
  );

  uart_transmitter u_dut_def (
    .clk(clk), .rst(rst), .tx_data(tx_data_d), .tx_valid(tx_valid_d),
    .tx_ready(tx_ready_d), .uart_out(uart_out_d), .tx_busy(tx_busy_d)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Passive frame decoder for the fast instance, sampling mid-bit on negedges.
  always begin
    @(negedge clk);
    if (dec_en && !rst && uart_out === 1'b0) begin
      dec_start = cyc;
      repeat (2) @(negedge clk);
      for (int j = 0; j < 8; j++) begin
        repeat (4) @(negedge clk);
        dec_byte[j] = uart_out;
      end
      repeat (4) @(negedge clk);
      if (uart_out !== 1'b1) stop_bad++;
      dec_q.push_back(dec_byte);
      start_q.push_back(dec_start);
      @(negedge clk);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    int guard = 0;
    @(negedge clk);
    while (!tx_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("push_ready", tx_ready, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic wait_def_change(input int bound, output int at);
    logic prev;
    int   n;
    bit   seen;
    prev = uart_out_d;
    n    = 0;
    seen = 0;
    at   = -1;
    while (!seen && n < bound) begin
      tick();
      n++;
      if (uart_out_d !== prev) begin
        at   = cyc;
        seen = 1;
      end
    end
  endtask

  task automatic wait_idle(input string tag, input int bound, output int fall_cyc);
    int guard = 0;
    while (tx_busy && guard < bound) begin
      tick();
      guard++;
    end
    fall_cyc = cyc;
    check(tag, tx_busy, 0);
  endtask

  function automatic logic [7:0] q_at(input int i);
    return (i < dec_q.size()) ? dec_q[i] : 8'hxx;
  endfunction

  function automatic int s_at(input int i);
    return (i < start_q.size()) ? start_q[i] : -1000;
  endfunction

  logic [7:0]  burst [6] = '{8'h00, 8'hFF, 8'h55, 8'h81, 8'h3C, 8'h7E};
  int          acc_cyc [6];
  logic        ready_after [6];
  logic [39:0] obs;
  int          c_acc, at, fall, bad, k, guard, busy_fall;
  logic        ready_now;

  initial begin
    // Reset and idle behaviour
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_uart_out", uart_out, 1);
    check("reset_tx_ready", tx_ready, 1);
    check("reset_tx_busy", tx_busy, 0);
    check("reset_def_ready_line", {tx_ready_d, uart_out_d, tx_busy_d}, 3'b110);
    bad = 0;
    repeat (100) begin
      tick();
      if (uart_out !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    check("idle_hold_bad_cycles", bad, 0);

    // Default instance: 0x0D, first bit edges at multiples of 10417 cycles
    @(negedge clk);
    tx_data_d  = 8'h0D;
    tx_valid_d = 1'b1;
    tick();
    c_acc = cyc;
    tx_valid_d = 1'b0;
    check("def_busy_after_accept", tx_busy_d, 1);
    wait_def_change(10, at);
    check("def_fall_latency", at - c_acc, 1);
    check("def_start_level", uart_out_d, 0);
    fall = at;
    wait_def_change(10417 + 5, at);
    check("def_bit0_edge", at - fall, 10417);
    check("def_bit0_level", uart_out_d, 1);
    wait_def_change(10417 + 5, at);
    check("def_bit1_edge", at - fall, 20834);
    check("def_bit1_level", uart_out_d, 0);
    wait_def_change(10417 + 5, at);
    check("def_bit2_edge", at - fall, 31251);
    check("def_bit2_level", uart_out_d, 1);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("def_reset_line", uart_out_d, 1);
    check("def_reset_busy", tx_busy_d, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single byte 0xA5
    dec_en = 1'b1;
    push_byte(8'hA5);
    check("a5_busy_on_accept", tx_busy, 1);
    check("a5_line_idle_at_accept", uart_out, 1);
    obs = '0;
    for (int i = 0; i < 40; i++) begin
      tick();
      obs = {obs[38:0], uart_out};
    end
    check("a5_frame_hi", obs[39:32], 8'h0F);
    check("a5_frame_lo", obs[31:0], 32'h0F00F0FF);
    check("a5_busy_last_stop_cycle", tx_busy, 1);
    tick();
    check("a5_busy_fall", tx_busy, 0);
    check("a5_line_idle_after", uart_out, 1);
    repeat (4) tick();
    check("a5_decoded_count", dec_q.size(), 1);
    check("a5_decoded_byte", q_at(0), 8'hA5);

    // Burst of six with tx_valid held high
    dec_q.delete();
    start_q.delete();
    stop_bad = 0;
    @(negedge clk);
    k = 0;
    guard = 0;
    tx_data  = burst[0];
    tx_valid = 1'b1;
    while (k < 6 && guard < 500) begin
      ready_now = tx_ready;
      tick();
      guard++;
      if (ready_now) begin
        acc_cyc[k]     = cyc;
        ready_after[k] = tx_ready;
        k++;
        if (k < 6) tx_data = burst[k];
        else       tx_valid = 1'b0;
      end
      @(negedge clk);
    end
    tx_valid = 1'b0;
    check("burst_accept_count", k, 6);
    for (int j = 0; j < 5; j++)
      check($sformatf("burst_ready_after_accept%0d", j), ready_after[j], (j < 4) ? 1 : 0);
    check("burst_first5_contiguous", acc_cyc[4] - acc_cyc[0], 4);
    check("burst_full_corner_delta", acc_cyc[5] - acc_cyc[0], 42);
    check("burst_ready_after_6th", ready_after[5], 0);
    wait_idle("burst_busy_fall", 400, busy_fall);
    check("burst_busy_fall_cycle", busy_fall - acc_cyc[0], 241);
    repeat (4) tick();
    check("burst_decoded_count", dec_q.size(), 6);
    for (int j = 0; j < 6; j++)
      check($sformatf("burst_byte%0d", j), q_at(j), burst[j]);
    for (int j = 1; j < 6; j++)
      check($sformatf("burst_pitch%0d", j), s_at(j) - s_at(j - 1), 40);
    check("burst_stop_bits", stop_bad, 0);

    // Asynchronous reset in bit 3 of 0x0F with two more bytes queued
    dec_en = 1'b0;
    push_byte(8'h0F);
    push_byte(8'h99);
    push_byte(8'h77);
    repeat (16) @(posedge clk);
    #2;
    check("rst_pre_bit3_level", uart_out, 1);
    check("rst_pre_busy", tx_busy, 1);
    rst = 1'b1;
    #1;
    check("rst_async_line", uart_out, 1);
    check("rst_async_busy", tx_busy, 0);
    check("rst_async_ready", tx_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (60) begin
      tick();
      if (uart_out !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    check("rst_fifo_discarded", bad, 0);
    dec_q.delete();
    start_q.delete();
    stop_bad = 0;
    dec_en = 1'b1;
    push_byte(8'h42);
    wait_idle("post_rst_busy_fall", 100, busy_fall);
    repeat (4) tick();
    check("post_rst_decoded_count", dec_q.size(), 1);
    check("post_rst_decoded_byte", q_at(0), 8'h42);
    check("post_rst_stop_bit", stop_bad, 0);

    // Reset while the line is low must raise it with no clock edge
    dec_en = 1'b0;
    push_byte(8'h00);
    repeat (10) @(posedge clk);
    #2;
    check("async_pre_level", uart_out, 0);
    rst = 1'b1;
    #1;
    check("async_rst_level", uart_out, 1);
    check("async_rst_busy", tx_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("async_post_idle", uart_out, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
